// File: rtl/inst_sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : inst_sram_ctrl
//  Description : Instruction-side controller for the off-chip base SRAM.
//                Turns the PC stage's single-cycle request into a multi-cycle
//                asynchronous SRAM read or write. It holds the pipeline stalled
//                until the access completes and presents the fetched word on
//                inst_o.
//                Optional macro SRAM_FETCH_BYPASS_EN adds a one-entry
//                last-read buffer. A read that hits this buffer skips the
//                SRAM cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_sram_ctrl #(
    parameter int ADDR_W     = 20,
    parameter int READ_WAIT  = 1,
    parameter int WRITE_WAIT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce_i,
    input  logic              op_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       wr_data_i,
    output logic [31:0]       inst_o,
    output logic              stallreq_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    input  logic [31:0]       sram_data_i,
    output logic [31:0]       sram_data_o,
    output logic              sram_data_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_be_n
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_READ  = 3'd1;
    localparam logic [2:0] c_ST_WRITE = 3'd2;
    localparam logic [2:0] c_ST_WREC  = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    // The write counter starts one lower because the last WE_n-low cycle is
    // the one that sees cnt == 0.
    localparam logic [2:0] c_RD_CNT = 3'(READ_WAIT);
    localparam logic [2:0] c_WR_CNT = 3'(WRITE_WAIT - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [2:0]        r_cnt;
    logic [ADDR_W-1:0] w_word_addr;
    logic              w_hit;
    logic [31:0]       w_buf_data;
    logic              w_unused_addr;

    assign w_word_addr   = addr_i[ADDR_W+1:2];
    assign w_unused_addr = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};

`ifdef SRAM_FETCH_BYPASS_EN
    logic              r_buf_valid;
    logic [ADDR_W-1:0] r_buf_tag;
    logic [31:0]       r_buf_data;

    assign w_hit      = r_buf_valid && !op_i && (r_buf_tag == w_word_addr);
    assign w_buf_data = r_buf_data;

    // Keep a copy of the last word read from SRAM, and keep it coherent with
    // writes to the same word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_valid <= 1'b0;
            r_buf_tag   <= '0;
            r_buf_data  <= '0;
        end else if (r_state == c_ST_READ && r_cnt == 3'd0) begin
            r_buf_valid <= 1'b1;
            r_buf_tag   <= sram_addr_o;
            r_buf_data  <= sram_data_i;
        end else if (r_state == c_ST_WREC && r_buf_valid && r_buf_tag == sram_addr_o) begin
            r_buf_data  <= sram_data_o;
        end
    end
`else
    assign w_hit      = 1'b0;
    assign w_buf_data = '0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (ce_i) begin
                    if (op_i) begin
                        w_state_nxt = c_ST_WRITE;
                    end else if (w_hit) begin
                        w_state_nxt = c_ST_DONE;
                    end else begin
                        w_state_nxt = c_ST_READ;
                    end
                end
            end
            c_ST_READ: begin
                if (r_cnt == 3'd0) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_WRITE: begin
                if (r_cnt == 3'd0) begin
                    w_state_nxt = c_ST_WREC;
                end
            end
            c_ST_WREC: w_state_nxt = c_ST_DONE;
            c_ST_DONE: w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Datapath: latch the request on accept, run the wait counter, capture read data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= 3'd0;
            inst_o      <= '0;
            sram_addr_o <= '0;
            sram_data_o <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (ce_i) begin
                        sram_addr_o <= w_word_addr;
                        sram_data_o <= wr_data_i;
                        r_cnt       <= op_i ? c_WR_CNT : c_RD_CNT;
                        if (w_hit) begin
                            inst_o <= w_buf_data;
                        end
                    end else begin
                        inst_o <= '0;
                    end
                end
                c_ST_READ: begin
                    if (r_cnt != 3'd0) begin
                        r_cnt <= r_cnt - 3'd1;
                    end else begin
                        inst_o <= sram_data_i;
                    end
                end
                c_ST_WRITE: begin
                    if (r_cnt != 3'd0) begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // SRAM strobes and stall request, decoded from state (accept-cycle stall is combinational)
    always_comb begin
        sram_ce_n    = 1'b1;
        sram_oe_n    = 1'b1;
        sram_we_n    = 1'b1;
        sram_data_oe = 1'b0;
        stallreq_o   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                stallreq_o = ce_i && !rst;
            end
            c_ST_READ: begin
                sram_ce_n  = 1'b0;
                sram_oe_n  = 1'b0;
                stallreq_o = 1'b1;
            end
            c_ST_WRITE: begin
                sram_ce_n    = 1'b0;
                sram_we_n    = 1'b0;
                sram_data_oe = 1'b1;
                stallreq_o   = 1'b1;
            end
            c_ST_WREC: begin
                // WE_n rises while data is still driven, giving hold time
                sram_ce_n    = 1'b0;
                sram_data_oe = 1'b1;
                stallreq_o   = 1'b1;
            end
            default: begin
            end
        endcase
        sram_be_n = sram_ce_n ? 4'hF : 4'h0;
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_sram_ctrl
//  Description : Directed self-checking bench for inst_sram_ctrl with a small
//                asynchronous SRAM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_sram_ctrl;

    // {stallreq, ce_n, oe_n, we_n, data_oe}
    localparam logic [31:0] c_ACC   = 32'h1E;
    localparam logic [31:0] c_READ  = 32'h12;
    localparam logic [31:0] c_WRITE = 32'h15;
    localparam logic [31:0] c_WREC  = 32'h17;
    localparam logic [31:0] c_NOREQ = 32'h0E;

`ifdef SRAM_FETCH_BYPASS_EN
    localparam int   c_HIT_LAT  = 2;
    localparam logic c_HIT_SRAM = 1'b0;
`else
    localparam int   c_HIT_LAT  = 4;
    localparam logic c_HIT_SRAM = 1'b1;
`endif

    logic        clk;
    logic        rst;
    logic        ce_i;
    logic        op_i;
    logic [31:0] addr_i;
    logic [31:0] wr_data_i;
    logic [31:0] inst_o;
    logic        stallreq_o;
    logic [19:0] sram_addr_o;
    logic [31:0] sram_data_i;
    logic [31:0] sram_data_o;
    logic        sram_data_oe;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic [3:0]  sram_be_n;

    int n_checks;
    int n_errors;
    int viol;
    logic mon_en;

    logic [31:0] mem [0:63];
    logic        prev_we_low;

    inst_sram_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .ce_i         (ce_i),
        .op_i         (op_i),
        .addr_i       (addr_i),
        .wr_data_i    (wr_data_i),
        .inst_o       (inst_o),
        .stallreq_o   (stallreq_o),
        .sram_addr_o  (sram_addr_o),
        .sram_data_i  (sram_data_i),
        .sram_data_o  (sram_data_o),
        .sram_data_oe (sram_data_oe),
        .sram_ce_n    (sram_ce_n),
        .sram_oe_n    (sram_oe_n),
        .sram_we_n    (sram_we_n),
        .sram_be_n    (sram_be_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Async SRAM: reads are combinational; a write commits only when WE_n
    // rises while CE_n is still low and data is still driven.
    assign sram_data_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr_o[5:0]] : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        if (!sram_ce_n && sram_we_n && sram_data_oe && prev_we_low) begin
            mem[sram_addr_o[5:0]] = sram_data_o;
        end
        prev_we_low = !sram_ce_n && !sram_we_n;
    end

    // Strobe rules that must hold in every cycle
    always @(negedge clk) begin
        if (mon_en) begin
            if (!sram_we_n && !sram_oe_n) viol++;
            if (sram_data_oe && !sram_oe_n) viol++;
            if (!sram_ce_n && sram_be_n != 4'h0) viol++;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic ctl(input string tag, input logic [31:0] exp);
        chk(tag, {27'd0, stallreq_o, sram_ce_n, sram_oe_n, sram_we_n, sram_data_oe}, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE and follow it through DONE, back into IDLE
    task automatic txn(input string tag, input logic op, input logic [31:0] addr,
                       input logic [31:0] data, input int exp_lat,
                       input logic [31:0] exp_inst, input logic exp_sram);
        int   lat;
        logic saw_ce;
        ce_i = 1'b1; op_i = op; addr_i = addr; wr_data_i = data;
        #1;
        lat    = 1;
        saw_ce = 1'b0;
        chk({tag, "_acc"}, {31'd0, stallreq_o}, 32'd1);
        if (!sram_ce_n) saw_ce = 1'b1;
        step;
        ce_i = 1'b0;
        #1;
        while (stallreq_o && lat < 20) begin
            if (!sram_ce_n) saw_ce = 1'b1;
            lat++;
            step;
            #1;
        end
        lat++;
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_inst"}, inst_o, exp_inst);
        chk({tag, "_sram"}, {31'd0, saw_ce}, {31'd0, exp_sram});
        step;
    endtask

    initial begin
        n_checks = 0; n_errors = 0; viol = 0; mon_en = 1'b0;
        prev_we_low = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0] = 32'h1111_1111;
        mem[1] = 32'h2222_2222;
        mem[4] = 32'h2402_0005;
        rst = 1'b1; ce_i = 1'b0; op_i = 1'b0; addr_i = 32'h0; wr_data_i = 32'h0;

        // Reset
        step; step; #1;
        mon_en = 1'b1;
        ctl("rst_ctl", c_NOREQ);
        chk("rst_be", {28'd0, sram_be_n}, 32'hF);
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_addr", {12'd0, sram_addr_o}, 32'h0);
        chk("rst_wdata", sram_data_o, 32'h0);
        rst = 1'b0;

        // Single read of word 4
        ce_i = 1'b1; op_i = 1'b0; addr_i = 32'h10; #1;
        ctl("rd_c1", c_ACC);
        step; ce_i = 1'b0; #1;
        ctl("rd_c2", c_READ);
        chk("rd_addr", {12'd0, sram_addr_o}, 32'd4);
        chk("rd_be", {28'd0, sram_be_n}, 32'h0);
        step; #1; ctl("rd_c3", c_READ);
        step; #1; ctl("rd_c4", c_NOREQ);
        chk("rd_inst", inst_o, 32'h2402_0005);
        step; #1; ctl("rd_idle", c_NOREQ);

        // Write 0xDEADBEEF to word 8, accepted in the first IDLE cycle
        ce_i = 1'b1; op_i = 1'b1; addr_i = 32'h20; wr_data_i = 32'hDEAD_BEEF; #1;
        ctl("wr_c1", c_ACC);
        chk("wr_idle_hold", inst_o, 32'h2402_0005);
        step; ce_i = 1'b0; op_i = 1'b0; #1;
        ctl("wr_c2", c_WRITE);
        chk("wr_addr", {12'd0, sram_addr_o}, 32'd8);
        chk("wr_data", sram_data_o, 32'hDEAD_BEEF);
        step; #1; ctl("wr_c3", c_WRITE);
        step; #1; ctl("wr_c4", c_WREC);
        step; #1; ctl("wr_c5", c_NOREQ);
        chk("wr_mem", mem[8], 32'hDEAD_BEEF);
        chk("wr_inst_keep", inst_o, 32'h2402_0005);
        step; #1;
        step; #1;
        chk("idle_nop", inst_o, 32'h0);

        // Back-to-back reads with ce_i held; mid-transaction input changes ignored
        ce_i = 1'b1; op_i = 1'b0; addr_i = 32'h0; #1;
        ctl("b2b_c1", c_ACC);
        step; op_i = 1'b1; addr_i = 32'h3C; #1;
        ctl("b2b_c2", c_READ);
        step; #1;
        ctl("b2b_c3", c_READ);
        chk("b2b_ign_addr", {12'd0, sram_addr_o}, 32'd0);
        step; op_i = 1'b0; addr_i = 32'h4; #1;
        ctl("b2b_c4", c_NOREQ);
        chk("b2b_inst0", inst_o, 32'h1111_1111);
        step; #1;
        ctl("b2b_c5", c_ACC);
        chk("b2b_hold", inst_o, 32'h1111_1111);
        step; ce_i = 1'b0; #1;
        ctl("b2b_c6", c_READ);
        chk("b2b_addr1", {12'd0, sram_addr_o}, 32'd1);
        step; #1; ctl("b2b_c7", c_READ);
        step; #1; ctl("b2b_c8", c_NOREQ);
        chk("b2b_inst1", inst_o, 32'h2222_2222);
        step; #1;

        // Reset in the second WRITE cycle aborts the write
        ce_i = 1'b1; op_i = 1'b1; addr_i = 32'h30; wr_data_i = 32'hCAFE_F00D; #1;
        ctl("abort_c1", c_ACC);
        step; ce_i = 1'b0; op_i = 1'b0; #1;
        ctl("abort_c2", c_WRITE);
        step; rst = 1'b1; #1;
        ctl("abort_c3", c_WRITE);
        step; #1;
        ctl("abort_idle", c_NOREQ);
        chk("abort_addr", {12'd0, sram_addr_o}, 32'h0);
        rst = 1'b0;
        step; step; #1;
        chk("abort_mem", mem[12], 32'h0);

        // Repeated read of word 4, then write it and read it again
        txn("rpt_rd1", 1'b0, 32'h10, 32'h0, 4, 32'h2402_0005, 1'b1);
        txn("rpt_rd2", 1'b0, 32'h10, 32'h0, c_HIT_LAT, 32'h2402_0005, c_HIT_SRAM);
        txn("rpt_wr",  1'b1, 32'h10, 32'h1, 5, 32'h2402_0005, 1'b1);
        chk("rpt_mem", mem[4], 32'h1);
        txn("rpt_rd3", 1'b0, 32'h10, 32'h0, c_HIT_LAT, 32'h0000_0001, c_HIT_SRAM);

        chk("ctl_rules", 32'(viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
